// File: rtl/clk_tick_pkg.sv
// ============================================================================
// Module   : clk_tick_pkg
// Purpose  : Shared channel-state encoding and default timing constants for
//            the divided-clock tick receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_tick_pkg;

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } chan_state_e;

    localparam int WDT_W_DEF       = 21;
    localparam int TIMEOUT_1K_DEF  = 200000;
    localparam int TIMEOUT_100_DEF = 2000000;

endpackage

`default_nettype wire

// File: rtl/clk_tick_channel.sv
// ============================================================================
// Module   : clk_tick_channel
// Purpose  : One divided-clock channel: synchroniser, rising-edge tick,
//            ARM/RUN/STALL watchdog. Optional tick counter under TICK_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_tick_channel
    import clk_tick_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WDT_W       = WDT_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_1K_DEF
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_async,
    input  logic        i_fault_clr,
    output logic        o_tick,
    output logic        o_stall
`ifdef TICK_COUNT_EN
    ,
    output logic [15:0] o_tick_cnt
`endif
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("clk_tick_channel: SYNC_STAGES must be in 2..4");
        end
        if (TIMEOUT < 1 ||
            longint'(TIMEOUT) > ((longint'(1) << WDT_W) - longint'(1))) begin : g_bad_timeout
            $error("clk_tick_channel: TIMEOUT must be in 1..2^WDT_W-1");
        end
    endgenerate

    localparam logic [WDT_W-1:0] c_wdt_last = WDT_W'(TIMEOUT - 1);
    localparam logic [WDT_W-1:0] c_wdt_max  = '1;
    localparam logic [2:0]       c_arm_last = 3'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] r_sync_q, w_sync_d;
    logic                   r_prev_q, w_prev_d;
    logic                   r_tick_q, w_tick_d;
    logic                   r_stall_q, w_stall_d;
    logic [WDT_W-1:0]       r_wdt_q, w_wdt_d;
    logic [2:0]             r_arm_q, w_arm_d;
    chan_state_e            r_state_q, w_state_d;
    logic                   w_sync_out;
    logic                   w_rise;

    assign w_sync_out = r_sync_q[SYNC_STAGES-1];
    assign w_rise     = w_sync_out & ~r_prev_q;

    always_comb begin
        w_sync_d  = {r_sync_q[SYNC_STAGES-2:0], i_async};
        w_state_d = r_state_q;
        w_prev_d  = r_prev_q;
        w_tick_d  = 1'b0;
        w_stall_d = r_stall_q;
        w_wdt_d   = r_wdt_q;
        w_arm_d   = r_arm_q;

        case (r_state_q)
            ARM: begin
                // Seeding prev on exit suppresses a tick for an input already high.
                if (r_arm_q == c_arm_last) begin
                    w_state_d = RUN;
                    w_prev_d  = w_sync_out;
                end else begin
                    w_arm_d = r_arm_q + 3'd1;
                end
            end
            RUN: begin
                w_prev_d = w_sync_out;
                w_tick_d = w_rise;
                if (w_rise) begin
                    w_wdt_d = '0;
                end else if (r_wdt_q == c_wdt_last) begin
                    w_state_d = STALL;
                    w_stall_d = 1'b1;
                end else if (r_wdt_q != c_wdt_max) begin
                    w_wdt_d = r_wdt_q + 1'b1;
                end
            end
            STALL: begin
                w_prev_d = w_sync_out;
                w_tick_d = w_rise;
                if (i_fault_clr) begin
                    w_state_d = RUN;
                    w_stall_d = 1'b0;
                    w_wdt_d   = '0;
                end
            end
            default: begin
                w_state_d = ARM;
                w_stall_d = 1'b0;
                w_wdt_d   = '0;
                w_arm_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_sync_q  <= '0;
            r_prev_q  <= 1'b0;
            r_tick_q  <= 1'b0;
            r_stall_q <= 1'b0;
            r_wdt_q   <= '0;
            r_arm_q   <= '0;
            r_state_q <= ARM;
        end else begin
            r_sync_q  <= w_sync_d;
            r_prev_q  <= w_prev_d;
            r_tick_q  <= w_tick_d;
            r_stall_q <= w_stall_d;
            r_wdt_q   <= w_wdt_d;
            r_arm_q   <= w_arm_d;
            r_state_q <= w_state_d;
        end
    end

    assign o_tick  = r_tick_q;
    assign o_stall = r_stall_q;

`ifdef TICK_COUNT_EN
    logic [15:0] r_tcnt_q, w_tcnt_d;

    always_comb begin
        w_tcnt_d = r_tcnt_q + {15'd0, w_tick_d};
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_tcnt_q <= '0;
        end else begin
            r_tcnt_q <= w_tcnt_d;
        end
    end

    assign o_tick_cnt = r_tcnt_q;
`endif

endmodule

`default_nettype wire

// File: rtl/clk_tick_receiver.sv
// ============================================================================
// Module   : clk_tick_receiver
// Purpose  : Turns the 1 kHz and 100 Hz divided clocks into one-cycle ticks in
//            the 100 MHz domain, with per-channel stall watchdogs. Define
//            TICK_COUNT_EN to add the 16-bit tick counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_tick_receiver
    import clk_tick_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WDT_W       = WDT_W_DEF,
    parameter int TIMEOUT_1K  = TIMEOUT_1K_DEF,
    parameter int TIMEOUT_100 = TIMEOUT_100_DEF
) (
    input  logic        clk_in_100m_hz,
    input  logic        rst_n,
    input  logic        clk_1000_hz_in,
    input  logic        clk_100_hz_in,
    input  logic        fault_clr,
    output logic        tick_1k,
    output logic        tick_100,
    output logic        stall_1k,
    output logic        stall_100
`ifdef TICK_COUNT_EN
    ,
    output logic [15:0] tick_cnt_1k,
    output logic [15:0] tick_cnt_100
`endif
);

    clk_tick_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .WDT_W       (WDT_W),
        .TIMEOUT     (TIMEOUT_1K)
    ) u_ch_1k (
        .clk         (clk_in_100m_hz),
        .i_rst_n     (rst_n),
        .i_async     (clk_1000_hz_in),
        .i_fault_clr (fault_clr),
        .o_tick      (tick_1k),
        .o_stall     (stall_1k)
`ifdef TICK_COUNT_EN
        ,
        .o_tick_cnt  (tick_cnt_1k)
`endif
    );

    clk_tick_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .WDT_W       (WDT_W),
        .TIMEOUT     (TIMEOUT_100)
    ) u_ch_100 (
        .clk         (clk_in_100m_hz),
        .i_rst_n     (rst_n),
        .i_async     (clk_100_hz_in),
        .i_fault_clr (fault_clr),
        .o_tick      (tick_100),
        .o_stall     (stall_100)
`ifdef TICK_COUNT_EN
        ,
        .o_tick_cnt  (tick_cnt_100)
`endif
    );

endmodule

`default_nettype wire

// File: tb/tb_clk_tick_receiver.sv
// ============================================================================
// Module   : tb_clk_tick_receiver
// Purpose  : Self-checking bench for clk_tick_receiver (TICK_COUNT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_tick_receiver;

    localparam int c_sync   = 2;
    localparam int c_to_1k  = 50;
    localparam int c_to_100 = 80;

    logic clk = 1'b0;
    logic rst_n, in_1k, in_100, fault_clr;
    logic tick_1k, tick_100, stall_1k, stall_100;
`ifdef TICK_COUNT_EN
    logic [15:0] tick_cnt_1k, tick_cnt_100;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: ticks are rising edges of the sampled input seen
    // c_sync edges late, muted until the arm window has passed.
    int                edges_hi;
    logic [c_sync+1:0] hist    [2];
    int                since   [2];
    bit                stall_m [2];
    bit                tick_m  [2];
    int                cnt_m   [2];
    int                tmo     [2] = '{c_to_1k, c_to_100};

    clk_tick_receiver #(
        .SYNC_STAGES (c_sync),
        .WDT_W       (21),
        .TIMEOUT_1K  (c_to_1k),
        .TIMEOUT_100 (c_to_100)
    ) dut (
        .clk_in_100m_hz (clk),
        .rst_n          (rst_n),
        .clk_1000_hz_in (in_1k),
        .clk_100_hz_in  (in_100),
        .fault_clr      (fault_clr),
        .tick_1k        (tick_1k),
        .tick_100       (tick_100),
        .stall_1k       (stall_1k),
        .stall_100      (stall_100)
`ifdef TICK_COUNT_EN
        ,
        .tick_cnt_1k    (tick_cnt_1k),
        .tick_cnt_100   (tick_cnt_100)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit rst_low, input bit clr, input bit x0, input bit x1);
        bit xs [2];
        xs[0] = x0;
        xs[1] = x1;
        if (rst_low) begin
            edges_hi = 0;
            for (int ch = 0; ch < 2; ch++) begin
                hist[ch] = '0; since[ch] = 0; stall_m[ch] = 1'b0;
                tick_m[ch] = 1'b0; cnt_m[ch] = 0;
            end
        end else begin
            edges_hi++;
            for (int ch = 0; ch < 2; ch++) begin
                hist[ch]   = {hist[ch][c_sync:0], xs[ch]};
                tick_m[ch] = (edges_hi >= c_sync + 2) && hist[ch][c_sync] && !hist[ch][c_sync+1];
                if (edges_hi >= c_sync + 2) begin
                    if (stall_m[ch]) begin
                        if (clr) begin
                            stall_m[ch] = 1'b0;
                            since[ch]   = 0;
                        end
                    end else if (tick_m[ch]) begin
                        since[ch] = 0;
                    end else begin
                        since[ch]++;
                        if (since[ch] >= tmo[ch]) stall_m[ch] = 1'b1;
                    end
                end
                if (tick_m[ch]) cnt_m[ch] = (cnt_m[ch] + 1) % 65536;
            end
        end
    endtask

    task automatic step(input bit r, input bit a, input bit b, input bit clr);
        rst_n = r; in_1k = a; in_100 = b; fault_clr = clr;
        @(posedge clk);
        model_edge(!r, clr, a, b);
        #1;
        cyc++;
        chk("tick_1k",   16'(tick_1k),   16'(tick_m[0]));
        chk("tick_100",  16'(tick_100),  16'(tick_m[1]));
        chk("stall_1k",  16'(stall_1k),  16'(stall_m[0]));
        chk("stall_100", 16'(stall_100), 16'(stall_m[1]));
`ifdef TICK_COUNT_EN
        chk("tick_cnt_1k",  tick_cnt_1k,  16'(cnt_m[0]));
        chk("tick_cnt_100", tick_cnt_100, 16'(cnt_m[1]));
`endif
    endtask

    function automatic bit walk(input bit v, input int odds);
        return v ^ ($urandom_range(0, odds - 1) == 0);
    endfunction

    initial begin
        bit b;
        bit a;
        int seen;
        int last_tick;
        int first_stall;
        rst_n = 1'b0; in_1k = 1'b0; in_100 = 1'b0; fault_clr = 1'b0;
        b = 1'b0;

        // Reset with the 1 kHz input already high: no tick during or after arm.
        repeat (5) step(0, 1, 0, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0);
            seen += int'(tick_1k);
        end
        chk("no_tick_high_release", 16'(seen), 16'd0);

        // Latency: input rises in cycle c, tick in cycle c+3 only.
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 0, 0); chk("lat_c1", 16'(tick_1k), 16'd0);
        step(1, 1, 0, 0); chk("lat_c2", 16'(tick_1k), 16'd0);
        step(1, 1, 0, 0); chk("lat_c3", 16'(tick_1k), 16'd1);
        step(1, 1, 0, 0); chk("lat_c4", 16'(tick_1k), 16'd0);

        // Period-40 toggling keeps the 1 kHz watchdog quiet.
        seen = 0;
        last_tick = -1;
        for (int i = 0; i < 1000; i++) begin
            b = walk(b, 16);
            step(1, (i % 40) < 20, b, 0);
            seen += int'(stall_1k);
            if (tick_1k) last_tick = cyc;
        end
        chk("no_stall_period40", 16'(seen), 16'd0);

        // Input held low: stall rises exactly 50 cycles after the last tick.
        first_stall = -1;
        for (int i = 0; i < 60; i++) begin
            b = walk(b, 16);
            step(1, 0, b, 0);
            if (tick_1k) last_tick = cyc;
            if (stall_1k && first_stall < 0) first_stall = cyc;
        end
        chk("stall_delay", 16'(first_stall - last_tick), 16'd50);
        chk("stall_sticky", 16'(stall_1k), 16'd1);

        // Ticks exactly 50 apart land on the timeout cycle; the tick must win.
        step(1, 0, b, 1);
        chk("clr_from_stall", 16'(stall_1k), 16'd0);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            b = walk(b, 16);
            step(1, (i % 50) < 25, b, 0);
            seen += int'(stall_1k);
        end
        chk("tick_wins_timeout", 16'(seen), 16'd0);
        repeat (60) step(1, 0, b, 0);
        chk("stall_again", 16'(stall_1k), 16'd1);

        // Clear coinciding with a tick, then a full fresh timeout.
        step(1, 1, b, 0);
        step(1, 1, b, 0);
        step(1, 1, b, 1);
        chk("clr_tick_tick", 16'(tick_1k), 16'd1);
        chk("clr_tick_stall", 16'(stall_1k), 16'd0);
        seen = 0;
        for (int i = 0; i < 49; i++) begin
            step(1, 1, b, 0);
            seen += int'(stall_1k);
        end
        chk("clr_tick_quiet49", 16'(seen), 16'd0);
        step(1, 1, b, 0);
        chk("clr_tick_stall50", 16'(stall_1k), 16'd1);

        // Reset in the cycle tick_100 is high drops the tick.
        repeat (5) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
        chk("pre_rst_tick_100", 16'(tick_100), 16'd1);
        step(0, 0, 1, 0);
        chk("rst_tick_100", 16'(tick_100), 16'd0);
        chk("rst_stall_1k", 16'(stall_1k), 16'd0);
        chk("rst_stall_100", 16'(stall_100), 16'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 0);
            seen += int'(tick_100);
        end
        chk("arm_high_no_tick", 16'(seen), 16'd0);

        // Rise sampled on the second release edge ticks on the first RUN edge.
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0); chk("arm_edge_c1", 16'(tick_100), 16'd0);
        step(1, 0, 1, 0); chk("arm_edge_c2", 16'(tick_100), 16'd0);
        step(1, 0, 1, 0); chk("arm_edge_c3", 16'(tick_100), 16'd1);
        step(1, 0, 1, 0); chk("arm_edge_c4", 16'(tick_100), 16'd0);

        // Randomised traffic with occasional clears and resets.
        a = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            a = walk(a, 12);
            b = walk(b, 12);
            step($urandom_range(0, 499) != 0, a, b, $urandom_range(0, 29) == 0);
        end

`ifdef TICK_COUNT_EN
        begin
            logic [15:0] saved;
            saved = 16'(cnt_m[0]);
            step(1, a, b, 1);
            chk("cnt_survives_clr", tick_cnt_1k, saved + 16'(tick_m[0]));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
